// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU operand sequencer
package alu_seq_pkg;

    localparam int WIDTH_DEF = 4;

    localparam int FLG_CERO = 0;
    localparam int FLG_NEG  = 1;
    localparam int FLG_COUT = 2;
    localparam int FLG_OVF  = 3;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    function automatic logic [3:0] pack_flags(
        input logic ovf,
        input logic cout,
        input logic neg,
        input logic cero
    );
        logic [3:0] f;
        f           = '0;
        f[FLG_OVF]  = ovf;
        f[FLG_COUT] = cout;
        f[FLG_NEG]  = neg;
        f[FLG_CERO] = cero;
        return f;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, stable-level debounce and rising-edge pulse
module btn_debounce #(
    parameter int DEB_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta_q, sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          pulse_q;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // The pulse is taken from the registered level, so it lands one cycle after the toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q      <= 1'b0;
            sync_q      <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            meta_q      <= btn_i;
            sync_q      <= meta_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            pulse_q     <= level_q & ~level_dly_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - collects A, B and op from switches, latches ALU flags
// Optional sticky overflow indicator enabled by SEQ_STICKY_OVF_EN.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEB_CYCLES = 200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_next,
    input  logic             btn_clr,
    input  logic             f_cero,
    input  logic             f_neg,
    input  logic             f_cout,
    input  logic             f_ovf,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Resta,
    output logic             OP1,
    output logic             op_valid,
    output logic [2:0]       stage,
    output logic [3:0]       flags_q,
    output logic             ovf_sticky
);

    logic [WIDTH-1:0] sw_meta_q, sw_sync_q;
    logic             next_pulse, clr_pulse;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             resta_q, resta_d, op1_q, op1_d;
    logic [3:0]       flags_d, flags_reg_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_next),
        .pulse_o (next_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_clr),
        .pulse_o (clr_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        resta_d = resta_q;
        op1_d   = op1_q;
        flags_d = flags_reg_q;
        unique case (state_q)
            S_A: if (next_pulse) begin
                a_d     = sw_sync_q;
                state_d = S_B;
            end
            S_B: if (next_pulse) begin
                b_d     = sw_sync_q;
                state_d = S_OP;
            end
            S_OP: if (next_pulse) begin
                resta_d = sw_sync_q[0];
                op1_d   = sw_sync_q[1];
                state_d = S_EXEC;
            end
            // Operands have been stable for the whole cycle, so the ALU flags are settled here.
            S_EXEC: begin
                flags_d = pack_flags(f_ovf, f_cout, f_neg, f_cero);
                state_d = S_SHOW;
            end
            S_SHOW: if (next_pulse) begin
                state_d = S_A;
            end
            default: state_d = S_A;
        endcase
        if (clr_pulse) begin
            a_d     = '0;
            b_d     = '0;
            resta_d = 1'b0;
            op1_d   = 1'b0;
            flags_d = '0;
            state_d = S_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            resta_q     <= 1'b0;
            op1_q       <= 1'b0;
            flags_reg_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            resta_q     <= resta_d;
            op1_q       <= op1_d;
            flags_reg_q <= flags_d;
        end
    end

`ifdef SEQ_STICKY_OVF_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (rst || clr_pulse) begin
            sticky_q <= 1'b0;
        end else if (state_q == S_EXEC && f_ovf) begin
            sticky_q <= 1'b1;
        end
    end

    assign ovf_sticky = sticky_q;
`else
    assign ovf_sticky = 1'b0;
`endif

    assign A        = a_q;
    assign B        = b_q;
    assign Resta    = resta_q;
    assign OP1      = op1_q;
    assign flags_q  = flags_reg_q;
    assign op_valid = (state_q == S_EXEC);
    assign stage    = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - directed and randomized checks of alu_operand_sequencer against a press-level model
module tb_alu_operand_sequencer;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw;
    logic         btn_next, btn_clr;
    logic         f_cero, f_neg, f_cout, f_ovf;
    logic [W-1:0] A, B;
    logic         Resta, OP1, op_valid;
    logic [2:0]   stage;
    logic [3:0]   flags_q;
    logic         ovf_sticky;

    int n_checks = 0;
    int n_pass   = 0;
    int ov_count = 0;

    int           m_stage;
    logic [W-1:0] m_a, m_b;
    logic         m_resta, m_op1, m_sticky;
    logic [3:0]   m_flags;
    int           m_ov;

    alu_operand_sequencer #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_next   (btn_next),
        .btn_clr    (btn_clr),
        .f_cero     (f_cero),
        .f_neg      (f_neg),
        .f_cout     (f_cout),
        .f_ovf      (f_ovf),
        .A          (A),
        .B          (B),
        .Resta      (Resta),
        .OP1        (OP1),
        .op_valid   (op_valid),
        .stage      (stage),
        .flags_q    (flags_q),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream 4-bit ALU flag logic: {ovf, cout, neg, cero}.
    function automatic logic [3:0] alu_flags(input logic [3:0] a, input logic [3:0] b,
                                             input logic sub, input logic op1);
        int ua, ub, raw, sa, sb, sres;
        logic ovf, cout, neg, cero;
        ua   = int'(a);
        ub   = int'(b);
        raw  = sub ? ua + (15 - ub) + 1 : ua + ub;
        sa   = (ua > 7) ? ua - 16 : ua;
        sb   = (ub > 7) ? ub - 16 : ub;
        sres = sub ? sa - sb : sa + sb;
        ovf  = (sres > 7) || (sres < -8);
        cout = raw > 15;
        cero = (raw % 16) == 0;
        neg  = sres < 0;
        if (op1) begin
            cero = 1'b0;
            neg  = 1'b0;
        end
        return {ovf, cout, neg, cero};
    endfunction

    always_comb {f_ovf, f_cout, f_neg, f_cero} = alu_flags(A, B, Resta, OP1);

    always @(negedge clk) begin
        if (op_valid === 1'b1) ov_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_stage  = 0;
        m_a      = '0;
        m_b      = '0;
        m_resta  = 1'b0;
        m_op1    = 1'b0;
        m_flags  = '0;
        m_sticky = 1'b0;
    endtask

    task automatic model_apply(input logic [3:0] v, input logic nxt, input logic clr);
        if (clr) begin
            model_reset();
        end else if (nxt) begin
            case (m_stage)
                0: begin m_a = v; m_stage = 1; end
                1: begin m_b = v; m_stage = 2; end
                2: begin
                    m_resta = v[0];
                    m_op1   = v[1];
                    m_flags = alu_flags(m_a, m_b, v[0], v[1]);
                    if (m_flags[3]) m_sticky = 1'b1;
                    m_ov++;
                    m_stage = 4;
                end
                default: m_stage = 0;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_sticky;
`ifdef SEQ_STICKY_OVF_EN
        exp_sticky = m_sticky;
`else
        exp_sticky = 1'b0;
`endif
        check({tag, ".stage"},    32'(stage),      32'(m_stage));
        check({tag, ".A"},        32'(A),          32'(m_a));
        check({tag, ".B"},        32'(B),          32'(m_b));
        check({tag, ".Resta"},    32'(Resta),      32'(m_resta));
        check({tag, ".OP1"},      32'(OP1),        32'(m_op1));
        check({tag, ".flags"},    32'(flags_q),    32'(m_flags));
        check({tag, ".sticky"},   32'(ovf_sticky), 32'(exp_sticky));
        check({tag, ".op_valid"}, 32'(op_valid),   32'(0));
        check({tag, ".op_count"}, 32'(ov_count),   32'(m_ov));
    endtask

    // One clean debounced press; an optional one-cycle glitch first must not register.
    task automatic press(input logic [3:0] v, input logic nxt, input logic clr);
        sw = v;
        tick(3);
        if ($urandom_range(0, 1) == 1) begin
            btn_next = nxt;
            btn_clr  = clr;
            tick(1);
            btn_next = 1'b0;
            btn_clr  = 1'b0;
            tick(2);
        end
        btn_next = nxt;
        btn_clr  = clr;
        tick(10);
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        tick(10);
        model_apply(v, nxt, clr);
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        if (m_stage == 4) press(4'd0, 1'b1, 1'b0);
        press(a, 1'b1, 1'b0);
        press(b, 1'b1, 1'b0);
        press(op, 1'b1, 1'b0);
    endtask

    initial begin
        logic [3:0] v;
        logic       c, n;
        m_ov     = 0;
        rst      = 1'b1;
        sw       = '0;
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(1);
        check_all("reset");

        do_op(4'd7, 4'd1, 4'd0);
        check_all("add_7_1");
        check("add_7_1.flags_const", 32'(flags_q), 32'(4'b1000));

        do_op(4'd3, 4'd3, 4'd1);
        check_all("sub_3_3");
        check("sub_3_3.flags_const", 32'(flags_q), 32'(4'b0101));

        do_op(4'd2, 4'd5, 4'd1);
        check_all("sub_2_5");
        check("sub_2_5.flags_const", 32'(flags_q), 32'(4'b0010));

        press(4'd0, 1'b1, 1'b0);
        check_all("back_to_a");
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            tick(2);
        end
        check("bounce.stage", 32'(stage), 32'(0));
        btn_next = 1'b1;
        tick(6);
        btn_next = 1'b0;
        tick(12);
        model_apply(sw, 1'b1, 1'b0);
        check_all("held6");
        check("held6.stage_const", 32'(stage), 32'(1));

        press(4'd9, 1'b1, 1'b0);
        check("to_op.stage", 32'(stage), 32'(2));
        press(4'd5, 1'b1, 1'b1);
        check_all("clr_vs_next");

        press(4'd6, 1'b1, 1'b0);
        check("pre_rst.stage", 32'(stage), 32'(1));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        check_all("rst_in_b");

        for (int i = 0; i < 24; i++) begin
            v = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 9) == 0);
            n = c ? 1'($urandom_range(0, 1)) : 1'b1;
            press(v, n, c);
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream stage of the 4-bit add/subtract ALU and its flag logic. Runs on board switches and pushbuttons.
- Collects operand A, operand B and the operation code from one 4-bit switch bank over successive debounced button presses.
- Holds the operands and operation stable for the ALU, then latches the returned Cero/Negativo/C_out/Overflow flags for display.

Parameters:
- WIDTH, 4: operand width; must match the ALU width.
- DEB_CYCLES, 200000: consecutive stable cycles required to accept a button level change (20 ms at 10 MHz). Bench uses 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw  in  WIDTH  switch bank, asynchronous to clk
- btn_next  in  1  advance button, raw and bouncy
- btn_clr  in  1  clear button, raw and bouncy
- f_cero, f_neg, f_cout, f_ovf  in  1 each  flags returned combinationally by the ALU flag logic
- A, B  out  WIDTH  registered operands to the ALU
- Resta  out  1  registered: 1 = subtract
- OP1  out  1  registered: 1 = non-arithmetic op, which suppresses Cero/Negativo downstream
- op_valid  out  1  one-cycle pulse while in S_EXEC
- stage  out  3  current state encoding, for LEDs
- flags_q  out  4  latched {ovf, cout, neg, cero}
- ovf_sticky  out  1  see Optional Feature

Behaviour:
- Reset (rst high at a clk edge): A=0, B=0, Resta=0, OP1=0, flags_q=0, ovf_sticky=0, op_valid=0, state=S_A. Debounce counters and debounced levels go to 0. A synchronous reset mid-sequence aborts the sequence with no flag capture.
- Input synchronisation: each button and each sw bit passes through 2 flops before use.
- Debounce: the counter increments while the synced level differs from the debounced level and resets to 0 when they are equal. When the counter reaches DEB_CYCLES-1 with the levels still differing, the debounced level toggles.
- Edge pulse: registered debounced-rising-edge pulse, one cycle wide, one cycle after the toggle. A button held through reset produces one pulse DEB_CYCLES after reset releases.
- State encoding: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
- Transitions on next_pulse:
  - S_A: A<=sw_sync, go to S_B.
  - S_B: B<=sw_sync, go to S_OP.
  - S_OP: Resta<=sw_sync[0], OP1<=sw_sync[1], go to S_EXEC.
  - S_SHOW: go to S_A. A, B and op keep their old values until overwritten.
- S_EXEC lasts exactly one cycle: op_valid=1, flags_q<={f_ovf,f_cout,f_neg,f_cero} sampled at the exiting edge, go to S_SHOW. Operands are stable for a full cycle before sampling, so the downstream combinational path gets one full cycle.
- next_pulse arriving in S_EXEC is ignored.
- clr_pulse from any state: A, B, Resta, OP1, flags_q and ovf_sticky <= 0, go to S_A.
- Simultaneous clr_pulse and next_pulse: clear wins. clr_pulse in S_EXEC: no flag capture, op_valid still 1 for that cycle.
- Width rule: A and B are captured as raw WIDTH-bit vectors. No sign or carry handling in this block.

Optional Feature:
- Macro: SEQ_STICKY_OVF_EN.
- Defined: ovf_sticky is set on every S_EXEC capture with f_ovf=1. It is cleared only by rst or clr_pulse and persists across S_SHOW->S_A cycles.
- Undefined: ovf_sticky is constant 0 and no flop is inferred.

Decomposition:
- Package alu_seq_pkg:
  - state_t enum with the encodings above
  - WIDTH_DEF=4
  - flag bit-index constants FLG_CERO=0, FLG_NEG=1, FLG_COUT=2, FLG_OVF=3
- Sub-module btn_debounce (synchroniser + counter + edge pulse, parameter DEB_CYCLES), instantiated twice.

Test Plan (DEB_CYCLES=4, real flag logic connected downstream):
- Three presses with sw=7, 1, 0 (add) -> A=7, B=1, Resta=0. op_valid high 1 cycle, then flags_q=4'b1000 (ovf=1, result 8).
- sw=3, 3, 1 (subtract) -> flags_q=4'b0101 (cout=1, cero=1). With SEQ_STICKY_OVF_EN, ovf_sticky stays 1 from the previous op.
- sw=2, 5, 1 -> flags_q neg=1, cout=0, ovf=0 (result 4'b1101).
- btn_next toggled every 2 cycles for 20 cycles -> no pulse, stage stays 0. Then held 6 cycles -> exactly one pulse, stage=1.
- btn_clr debounced while in S_OP with btn_next pulsing the same cycle -> stage=0, A=B=0, flags_q=0, op_valid never asserted.
- rst asserted for 1 cycle while in S_B -> all outputs 0 and stage=0 on the next cycle.
